pattern_detector: RTL and testbench

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/pattern_detector_pkg.sv | 27 ++
 rtl/pattern_detector_sat_counter.sv | 22 ++
 rtl/pattern_detector.sv | 86 ++++++++
 tb/tb_pattern_detector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detector_pkg.sv
// Shared types and constants for the serial pattern detector.
// The optional match counter is enabled by defining PATDET_MATCH_CNT_EN.
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int PAT_W_DEFAULT = 3;
    localparam int CNT_W_DEFAULT = 8;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector with overlapping/non-overlapping modes.
// Define PATDET_MATCH_CNT_EN to build the saturating match counter.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int                FILL_W    = clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

    state_t             state;
    logic [PAT_W-2:0]   history;
    logic [FILL_W-1:0]  fill;
    logic [PAT_W-1:0]   pat_reg;
    logic               armed_reg;
    logic [PAT_W-1:0]   window;

    // The oldest history bit lines up with pattern[PAT_W-1], the live sample with bit 0.
    assign window = {history, in};
    assign match  = en & ~rst & ~load & (state == ARMED) & (window == pat_reg);
    assign armed  = armed_reg & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            history   <= '0;
            fill      <= '0;
            pat_reg   <= '0;
            armed_reg <= 1'b0;
        end else if (load) begin
            pat_reg   <= pattern;
            history   <= '0;
            fill      <= '0;
            state     <= FILL;
            armed_reg <= 1'b0;
        end else if (en && (state != IDLE)) begin
            history <= window[PAT_W-2:0];
            if (match && !overlap) begin
                fill      <= '0;
                state     <= FILL;
                armed_reg <= 1'b0;
            end else if (fill == FILL_MAX) begin
                state     <= ARMED;
                armed_reg <= 1'b1;
            end else begin
                fill <= fill + 1'b1;
                if (fill == FILL_LAST) begin
                    state     <= ARMED;
                    armed_reg <= 1'b1;
                end
            end
        end
    end

`ifdef PATDET_MATCH_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_match_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (match),
        .clr  (clr_cnt),
        .count(match_cnt)
    );
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed self-checking bench for pattern_detector (PAT_W=3/CNT_W=8 and PAT_W=2/CNT_W=2).
// Expected counts follow PATDET_MATCH_CNT_EN: zero when the counter is not built.
module tb_pattern_detector;

`ifdef PATDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, din, load, overlap, clr_cnt;
    logic [2:0] pattern;
    logic       match, armed;
    logic [7:0] match_cnt;

    logic       rst2, en2, din2, load2, overlap2, clr2;
    logic [1:0] pattern2;
    logic       match2, armed2;
    logic [1:0] match_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_detector #(.PAT_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in(din), .load(load), .pattern(pattern),
        .overlap(overlap), .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt),
        .armed(armed)
    );

    pattern_detector #(.PAT_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .in(din2), .load(load2), .pattern(pattern2),
        .overlap(overlap2), .clr_cnt(clr2), .match(match2), .match_cnt(match_cnt2),
        .armed(armed2)
    );

    function automatic int exp_cnt(input int n);
        return CNT_EN ? n : 0;
    endfunction

    // Drive one sample, capture the combinational outputs, then step past the edge.
    task automatic sample(input logic e, input logic b, output logic m, output logic a);
        en  = e;
        din = b;
        #2;
        m = match;
        a = armed;
        @(posedge clk);
        #1;
    endtask

    task automatic sample2(input logic e, input logic b, output logic m);
        en2  = e;
        din2 = b;
        #2;
        m = match2;
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [2:0] p, input logic ov);
        logic m, a;
        load    = 1'b1;
        pattern = p;
        overlap = ov;
        sample(1'b0, 1'b0, m, a);
        load = 1'b0;
    endtask

    task automatic test_reset;
        logic m, a;
        rst = 1'b1; load = 1'b1; pattern = 3'b010; clr_cnt = 1'b1;
        sample(1'b1, 1'b0, m, a);
        checks++;
        if (m !== 1'b0) begin failures++; $display("[TB] FAIL reset_match: got %b expected 0", m); end
        checks++;
        if (a !== 1'b0) begin failures++; $display("[TB] FAIL reset_armed: got %b expected 0", a); end
        rst = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        checks++;
        if (armed !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_armed: got %b expected 0", armed); end
        checks++;
        if (match_cnt !== 8'd0) begin failures++; $display("[TB] FAIL post_reset_cnt: got %0d expected 0", match_cnt); end
        // Idle must discard samples: 0,1,0 would match if the load had been taken.
        for (int i = 0; i < 3; i++) begin
            sample(1'b1, (i == 1), m, a);
            checks++;
            if (m !== 1'b0) begin failures++; $display("[TB] FAIL idle_match[%0d]: got %b expected 0", i, m); end
        end
        checks++;
        if (armed !== 1'b0) begin failures++; $display("[TB] FAIL idle_armed: got %b expected 0", armed); end
    endtask

    task automatic run_stream(input string name, input logic [4:0] bits, input logic [4:0] exp);
        logic m, a;
        for (int i = 0; i < 5; i++) begin
            sample(1'b1, bits[4-i], m, a);
            checks++;
            if (m !== exp[4-i]) begin
                failures++;
                $display("[TB] FAIL %s_match[bit%0d]: got %b expected %b", name, i + 1, m, exp[4-i]);
            end
        end
    endtask

    task automatic test_non_overlap;
        load_pattern(3'b010, 1'b0);
        checks++;
        if (armed !== 1'b0) begin failures++; $display("[TB] FAIL load_armed: got %b expected 0", armed); end
        run_stream("nonovl", 5'b01010, 5'b00100);
        checks++;
        if (match_cnt !== 8'(exp_cnt(1))) begin
            failures++; $display("[TB] FAIL nonovl_cnt: got %0d expected %0d", match_cnt, exp_cnt(1));
        end
    endtask

    task automatic test_overlap;
        logic m, a;
        clr_cnt = 1'b1;
        sample(1'b0, 1'b0, m, a);
        clr_cnt = 1'b0;
        checks++;
        if (match_cnt !== 8'd0) begin failures++; $display("[TB] FAIL clr_cnt: got %0d expected 0", match_cnt); end
        load_pattern(3'b010, 1'b1);
        run_stream("ovl", 5'b01010, 5'b00101);
        checks++;
        if (match_cnt !== 8'(exp_cnt(2))) begin
            failures++; $display("[TB] FAIL ovl_cnt: got %0d expected %0d", match_cnt, exp_cnt(2));
        end
    endtask

    task automatic test_gap;
        logic m, a;
        load_pattern(3'b010, 1'b0);
        sample(1'b1, 1'b0, m, a);
        sample(1'b1, 1'b1, m, a);
        for (int i = 0; i < 4; i++) begin
            sample(1'b0, 1'b0, m, a);
            checks++;
            if (m !== 1'b0) begin failures++; $display("[TB] FAIL gap_match[%0d]: got %b expected 0", i, m); end
        end
        checks++;
        if (armed !== 1'b1) begin failures++; $display("[TB] FAIL gap_armed: got %b expected 1", armed); end
        sample(1'b1, 1'b0, m, a);
        checks++;
        if (m !== 1'b1) begin failures++; $display("[TB] FAIL gap_final_match: got %b expected 1", m); end
    endtask

    task automatic test_reset_mid;
        logic m, a;
        load_pattern(3'b010, 1'b0);
        sample(1'b1, 1'b0, m, a);
        sample(1'b1, 1'b1, m, a);
        checks++;
        if (armed !== 1'b1) begin failures++; $display("[TB] FAIL mid_armed_before: got %b expected 1", armed); end
        rst = 1'b1;
        sample(1'b1, 1'b0, m, a);
        checks++;
        if (m !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_match: got %b expected 0", m); end
        checks++;
        if (a !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_armed: got %b expected 0", a); end
        rst = 1'b0;
        checks++;
        if (match_cnt !== 8'd0) begin failures++; $display("[TB] FAIL mid_reset_cnt: got %0d expected 0", match_cnt); end
        sample(1'b1, 1'b0, m, a);
        checks++;
        if (m !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_match: got %b expected 0", m); end
        checks++;
        if (armed !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_armed: got %b expected 0", armed); end
        load_pattern(3'b010, 1'b0);
        run_stream("mid_fresh", 5'b01000, 5'b00100);
    endtask

    task automatic test_load_collide;
        logic m, a;
        load_pattern(3'b010, 1'b0);
        sample(1'b1, 1'b0, m, a);
        sample(1'b1, 1'b1, m, a);
        load    = 1'b1;
        pattern = 3'b010;
        sample(1'b1, 1'b0, m, a);
        load = 1'b0;
        checks++;
        if (m !== 1'b0) begin failures++; $display("[TB] FAIL collide_match: got %b expected 0", m); end
        checks++;
        if (armed !== 1'b0) begin failures++; $display("[TB] FAIL collide_armed: got %b expected 0", armed); end
        run_stream("collide_refill", 5'b01000, 5'b00100);
    endtask

    task automatic test_saturate;
        logic m;
        int   n;
        rst2 = 1'b1;
        sample2(1'b0, 1'b0, m);
        rst2 = 1'b0; load2 = 1'b1; pattern2 = 2'b11; overlap2 = 1'b1;
        sample2(1'b0, 1'b0, m);
        load2 = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            sample2(1'b1, 1'b1, m);
            checks++;
            if (m !== (i != 0)) begin failures++; $display("[TB] FAIL sat_match[%0d]: got %b expected %b", i, m, (i != 0)); end
            if (i != 0) n++;
            checks++;
            if (match_cnt2 !== 2'(exp_cnt(n > 3 ? 3 : n))) begin
                failures++; $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", i, match_cnt2, exp_cnt(n > 3 ? 3 : n));
            end
        end
        clr2 = 1'b1;
        sample2(1'b1, 1'b1, m);
        clr2 = 1'b0;
        checks++;
        if (m !== 1'b1) begin failures++; $display("[TB] FAIL clr_with_match: got %b expected 1", m); end
        checks++;
        if (match_cnt2 !== 2'd0) begin failures++; $display("[TB] FAIL clr_wins_cnt: got %0d expected 0", match_cnt2); end
        sample2(1'b1, 1'b1, m);
        checks++;
        if (match_cnt2 !== 2'(exp_cnt(1))) begin
            failures++; $display("[TB] FAIL cnt_after_clr: got %0d expected %0d", match_cnt2, exp_cnt(1));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; load = 1'b0; pattern = '0; overlap = 1'b0; clr_cnt = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; din2 = 1'b0; load2 = 1'b0; pattern2 = '0; overlap2 = 1'b0; clr2 = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_non_overlap;
        test_overlap;
        test_gap;
        test_reset_mid;
        test_load_collide;
        test_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
